// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequences a full AES state through a byte-serial MixColumns datapath,
// capturing each mixed column and presenting the result on a valid/ready handshake.
module mix_columns_seq #(
    parameter int NUM_COLS  = 4,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [32*NUM_COLS-1:0] in_state,
    input  logic                   in_bypass,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [32*NUM_COLS-1:0] out_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             mc_in_byte,
    output logic [7:0]             mc_enable,
    input  logic [7:0]             mc_out_1,
    input  logic [7:0]             mc_out_2,
    input  logic [7:0]             mc_out_3,
    input  logic [7:0]             mc_out_4
);
    localparam int W  = 32*NUM_COLS;
    localparam int KW = $clog2(4*NUM_COLS);
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, OUT} state_t;
    state_t        r_state, w_next;
    logic [W-1:0]  r_held, r_out;
    logic [KW-1:0] r_k, w_col;
    logic          w_accept, w_bypass, w_cap;
    assign out_state = r_out;
    assign w_accept  = in_valid && r_state == IDLE;
    assign w_bypass  = BYPASS_EN && in_bypass;
    // A column is complete one edge after its last byte; the edge that feeds the next column's row 0 captures it.
    assign w_cap     = (r_state == FEED && r_k[1:0] == 2'd0 && r_k != '0) || r_state == FLUSH;
    assign w_col     = (r_state == FLUSH) ? KW'(NUM_COLS - 1) : (r_k >> 2) - KW'(1);
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mc_in_byte = '0;
        mc_enable  = '0;
        case (r_state)
            IDLE: begin
                in_ready = !reset;
                if (in_valid) w_next = w_bypass ? OUT : FEED;
            end
            FEED: begin
                mc_in_byte = r_held[W-1 -: 8];
                mc_enable  = (r_k[1:0] == 2'd0) ? 8'h00 : 8'hff;
                if (r_k == KW'(4*NUM_COLS - 1)) w_next = FLUSH;
            end
            FLUSH: w_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // The held copy shifts left so the next byte to feed always sits in the top byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_held <= '0;
            r_out  <= '0;
            r_k    <= '0;
        end else begin
            if (w_accept) begin
                r_held <= in_state;
                r_k    <= '0;
                if (w_bypass) r_out <= in_state;
            end
            if (r_state == FEED) begin
                r_held <= r_held << 8;
                r_k    <= r_k + KW'(1);
            end
            for (int c = 0; c < NUM_COLS; c++)
                if (w_cap && w_col == KW'(c)) r_out[W-1-32*c -: 32] <= {mc_out_1, mc_out_2, mc_out_3, mc_out_4};
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: random and directed checks of the MixColumns sequencer against a column-formula
// reference, with a behavioural byte-serial datapath model closing the loop for each instance.
module tb_mix_columns_seq;
    localparam int N = 4;
    localparam int W = 32*N;
    logic         clock = 1'b0, reset = 1'b1, sel = 1'b0;
    logic         in_valid = 1'b0, in_bypass = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_state = '0;
    logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [W-1:0] a_out_state, b_out_state;
    logic [7:0]   a_byte, a_en, b_byte, b_en;
    logic [7:0]   a_dp [4] = '{default: 8'h00};
    logic [7:0]   b_dp [4] = '{default: 8'h00};
    int           a_j = 0, b_j = 0;
    int           n_chk = 0, n_pass = 0;
    logic         v_ready, v_valid;
    logic [W-1:0] v_state;
    logic [7:0]   v_byte, v_en;
    always #5 clock = ~clock;
    assign v_ready = sel ? b_in_ready  : a_in_ready;
    assign v_valid = sel ? b_out_valid : a_out_valid;
    assign v_state = sel ? b_out_state : a_out_state;
    assign v_byte  = sel ? b_byte      : a_byte;
    assign v_en    = sel ? b_en        : a_en;
    mix_columns_seq #(.NUM_COLS(N), .BYPASS_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .in_state(in_state), .in_bypass(in_bypass),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready), .out_state(a_out_state),
        .out_valid(a_out_valid), .out_ready(out_ready), .mc_in_byte(a_byte), .mc_enable(a_en),
        .mc_out_1(a_dp[0]), .mc_out_2(a_dp[1]), .mc_out_3(a_dp[2]), .mc_out_4(a_dp[3]));
    mix_columns_seq #(.NUM_COLS(N), .BYPASS_EN(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .in_state(in_state), .in_bypass(in_bypass),
        .in_valid(in_valid && sel), .in_ready(b_in_ready), .out_state(b_out_state),
        .out_valid(b_out_valid), .out_ready(out_ready), .mc_in_byte(b_byte), .mc_enable(b_en),
        .mc_out_1(b_dp[0]), .mc_out_2(b_dp[1]), .mc_out_3(b_dp[2]), .mc_out_4(b_dp[3]));
    function automatic logic [7:0] x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gm(input logic [7:0] b, input int c);
        return (c == 1) ? b : (c == 2) ? x2(b) : x2(b) ^ b;
    endfunction
    function automatic int cf(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    // Datapath model: mask ANDs the accumulators, row r weights byte j by the circulant {2,3,1,1}.
    always @(posedge clock) begin
        for (int r = 0; r < 4; r++) begin
            a_dp[r] <= (a_dp[r] & a_en) ^ gm(a_byte, cf((((a_en == 8'h00) ? 0 : a_j) - r) & 3));
            b_dp[r] <= (b_dp[r] & b_en) ^ gm(b_byte, cf((((b_en == 8'h00) ? 0 : b_j) - r) & 3));
        end
        a_j <= (a_en == 8'h00) ? 1 : a_j + 1;
        b_j <= (b_en == 8'h00) ? 1 : b_j + 1;
    end
    function automatic logic [W-1:0] ref_mix(input logic [W-1:0] s);
        logic [W-1:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < N; c++) begin
            a0 = s[W-1-32*c -: 8];
            a1 = s[W-9-32*c -: 8];
            a2 = s[W-17-32*c -: 8];
            a3 = s[W-25-32*c -: 8];
            o[W-1-32*c -: 32] = {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                                 x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
        end
        return o;
    endfunction
    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic wait_ready();
        int t = 0;
        while (!v_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("in_ready", v_ready, 1);
    endtask
    task automatic run(input logic [W-1:0] s, input logic byp, input int hold, input logic bpen);
        logic [W-1:0] exp, sh;
        logic         fed;
        int           t;
        fed = !(byp && bpen);
        exp = fed ? ref_mix(s) : s;
        @(negedge clock);
        in_state  = s;
        in_bypass = byp;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        wait_ready();
        @(negedge clock);
        in_valid  = 1'b0;
        in_state  = rnd();
        in_bypass = ~byp;
        t = 0;
        while (!v_valid && t < 60) begin
            sh = s << (8*t);
            check("mc_in_byte", v_byte, (fed && t < 4*N) ? sh[W-1 -: 8] : 8'h00);
            check("mc_enable", v_en, (fed && t < 4*N && t % 4 != 0) ? 8'hff : 8'h00);
            @(negedge clock);
            t++;
        end
        check("latency", t, fed ? 4*N + 1 : 0);
        check("out_state", v_state, exp);
        check("mc_enable_out", v_en, 0);
        repeat (hold) begin
            check("hold_valid", v_valid, 1);
            check("hold_state", v_state, exp);
            check("hold_in_ready", v_ready, 0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("post_valid", v_valid, 0);
        check("post_in_ready", v_ready, 1);
        check("post_state", v_state, exp);
        out_ready = 1'b0;
    endtask
    initial begin
        logic [W-1:0] s1, s2, got1;
        int           t, rdy_t;
        repeat (2) @(negedge clock);
        check("rst_in_ready", a_in_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_idle_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_state", a_out_state, 0);
        check("rst_mc_enable", a_en, 0);
        check("rst_mc_in_byte", a_byte, 0);
        run(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 0, 1'b1);
        check("vector1", a_out_state, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        run(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b1, 0, 1'b1);
        check("vector3_byp", a_out_state, 128'hd4d4d4d5_2d26314c_00000000_ffffffff);
        sel = 1'b1;
        run(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b1, 0, 1'b0);
        check("vector3_nobyp", b_out_state, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
        sel = 1'b0;
        run(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 10, 1'b1);
        s1 = rnd();
        s2 = rnd();
        got1 = '0;
        @(negedge clock);
        in_state  = s1;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_ready();
        @(negedge clock);
        in_state = s2;
        t = 0;
        rdy_t = -1;
        while (t < 80 && rdy_t < 0) begin
            if (v_valid) got1 = v_state;
            if (v_ready) rdy_t = t;
            else begin
                @(negedge clock);
                t++;
            end
        end
        check("b2b_gap", rdy_t + 1, 4*N + 3);
        check("b2b_first", got1, ref_mix(s1));
        @(negedge clock);
        in_valid = 1'b0;
        t = 0;
        while (!v_valid && t < 60) begin
            @(negedge clock);
            t++;
        end
        check("b2b_latency", t, 4*N + 1);
        check("b2b_second", v_state, ref_mix(s2));
        @(negedge clock);
        out_ready = 1'b0;
        s1 = rnd();
        @(negedge clock);
        in_state = s1;
        in_valid = 1'b1;
        wait_ready();
        @(negedge clock);
        in_valid = 1'b0;
        repeat (7) @(negedge clock);
        check("abort_k7_en", a_en, 8'hff);
        check("abort_k7_byte", a_byte, s1[W-57 -: 8]);
        reset = 1'b1;
        @(negedge clock);
        check("abort_valid", a_out_valid, 0);
        check("abort_state", a_out_state, 0);
        check("abort_in_ready", a_in_ready, 0);
        check("abort_en", a_en, 0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_idle", a_in_ready, 1);
        run(rnd(), 1'b0, 0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom % 2);
            run(rnd(), 1'($urandom % 2), $urandom_range(0, 3), !sel);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
